timer_dev: RTL
==============

// Module: timer_dev
// PURPOSE
//   Memory-mapped 32-bit down-counting timer on the processor bridge.
//   Consumes the CPU's bridge write/read traffic (word address, data, write enable).
//   Produces an interrupt request that drives one bit of the CPU's HWInt[7:2] input.
//   Supports one-shot and auto-reload modes under software control.
// PARAMETERS
//   none
// PORTS
//   clk    in   1   system clock, all state updates on rising edge
//   rst    in   1   asynchronous, active-low reset
//   Addr   in   2   register select (bridge address bits [3:2])
//   We     in   1   write strobe, qualified by bridge device decode
//   DIn    in   32  write data from CPU
//   DOut   out  32  read data to bridge, combinational on Addr
//   IRQ    out  1   interrupt request to CPU HWInt
// BEHAVIOUR
// - Register map (word offsets):
//   - 0 CTRL: [0] En, [2:1] Mode, [3] IM; bits [31:4] read 0, writes ignored.
//     Mode 00 = one-shot, 01 = auto-reload; 1x behaves as 00.
//   - 1 PRESET: R/W, 32 bits.
//   - 2 COUNT: read-only; writes ignored.
//   - 3: reads 0, writes ignored.
// - Reset (rst=0, async): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state IDLE.
//   Hence DOut=CTRL=0 at Addr 0 and IRQ=0. Reset mid-count aborts immediately.
// - IRQ = irq_flag & IM, combinational. Clearing IM masks IRQ but keeps irq_flag.
// - FSM states: IDLE, LOAD, CNT, INT.
//   - IDLE: En=1 -> LOAD; COUNT holds its value.
//   - LOAD: COUNT<=PRESET -> CNT.
//   - CNT: En=0 -> IDLE, COUNT held.
//     COUNT>1 -> COUNT<=COUNT-1.
//     COUNT<=1 -> COUNT<=0, irq_flag<=1, -> INT.
//   - INT, Mode 00: En<=0, irq_flag stays 1, -> IDLE.
//   - INT, Mode 01: irq_flag<=0 (one-cycle pulse), -> LOAD.
// - Latency: CTRL write with En=1 at edge t.
//   - LOAD entered at t+1; COUNT=PRESET=N at t+2.
//   - irq_flag rises at edge t+2+N for N>=1, and at t+3 for N=0.
//   - Auto-reload period is N+2 cycles.
// - Any CPU write to CTRL clears irq_flag (interrupt acknowledge).
// - Simultaneous bus write and FSM update of CTRL: the bus value wins.
//   Example: a write with En=1 in the INT cycle of one-shot keeps En=1.
// - PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
// - Writing En=0 during LOAD: LOAD completes, then CNT sees En=0 -> IDLE.
// - COUNT never wraps below 0. Decrement is unsigned 32-bit.
//   PRESET=32'hFFFFFFFF is legal.
// TESTING
//   1 Reset: drive rst=0 mid-count -> IRQ=0, COUNT=0, CTRL=0 immediately, no clk edge needed.
//   2 One-shot: PRESET=5, CTRL=4'b1001 at edge t -> COUNT 5..1, IRQ=1 at t+7, En reads 0.
//     IRQ stays 1 until a CTRL write, then 0.
//   3 Auto-reload: PRESET=3, CTRL=4'b1011 -> IRQ one-cycle pulses every 5 cycles.
//     Check 4 consecutive periods.
//   4 Masking: one-shot with IM=0, PRESET=2 -> IRQ stays 0, irq_flag set.
//     A later write to CTRL with IM=1 clears the flag, so IRQ stays 0.
//   5 PRESET=0, En=1 -> IRQ at t+3; write PRESET=9 mid-CNT of PRESET=20 -> count unaffected.
//     The next auto-reload loads 9.
//   6 Read map: Addr=3 -> DOut=0; write 32'hFFFFFFFF to CTRL -> reads 32'h0000000F.
//     Write to COUNT -> no change.

Source files
------------

// File: rtl/timer_dev_if.sv
// Bridge-side bus bundle for the memory-mapped timer: register access plus IRQ,
// with a read-only debug view of the FSM state and the raw interrupt flag.
interface timer_dev_if;
   // No valid/ready: a write happens on every rising clk edge where We=1, to the
   // register that Addr selects; reads are combinational and need no strobe.
   logic [1:0]  Addr;
   logic        We;
   logic [31:0] DIn;
   logic [31:0] DOut;
   logic        IRQ;
   logic [1:0]  dbg_state;
   logic        dbg_irq_flag;

   modport master (
      output Addr, We, DIn,
      input  DOut, IRQ, dbg_state, dbg_irq_flag
   );

   modport slave (
      input  Addr, We, DIn,
      output DOut, IRQ, dbg_state, dbg_irq_flag
   );
endinterface

// File: rtl/timer_dev.sv
// 32-bit down-counting timer with one-shot and auto-reload modes. The interrupt
// flag is masked by CTRL.IM, and any CPU write to CTRL acknowledges it.
module timer_dev (
   input  logic        clk,
   input  logic        rst,
   timer_dev_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        irq_flag_q, irq_flag_d;

   logic        en;
   logic        auto_reload;

   assign en          = ctrl_q[0];
   // Modes 10 and 11 fall back to one-shot.
   assign auto_reload = (ctrl_q[2:1] == 2'b01);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ctrl_q     <= 4'd0;
         preset_q   <= 32'd0;
         count_q    <= 32'd0;
         irq_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      irq_flag_d = irq_flag_q;

      case (state_q)
         IDLE: begin
            if (en) state_d = LOAD;
         end
         LOAD: begin
            count_d = preset_q;
            state_d = CNT;
         end
         CNT: begin
            if (!en) begin
               state_d = IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d    = 32'd0;
               irq_flag_d = 1'b1;
               state_d    = INT;
            end
         end
         INT: begin
            if (auto_reload) begin
               irq_flag_d = 1'b0;
               state_d    = LOAD;
            end else begin
               ctrl_d[0] = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Bus writes are applied last so they override same-cycle FSM updates.
      if (bus.We) begin
         case (bus.Addr)
            2'd0: begin
               ctrl_d     = bus.DIn[3:0];
               irq_flag_d = 1'b0;
            end
            2'd1:    preset_d = bus.DIn;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (bus.Addr)
         2'd0:    bus.DOut = {28'd0, ctrl_q};
         2'd1:    bus.DOut = preset_q;
         2'd2:    bus.DOut = count_q;
         default: bus.DOut = 32'd0;
      endcase
   end

   assign bus.IRQ          = irq_flag_q & ctrl_q[3];
   assign bus.dbg_state    = state_q;
   assign bus.dbg_irq_flag = irq_flag_q;

endmodule
